// File: rtl/pistormx_pkg.sv
// Shared definitions for the PiStorm-X 68K transaction front end:
// register map, STATUS bit layout and the queued command format.
package pistormx_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int unsigned STAT_FULL     = 0;
    localparam int unsigned STAT_PENDING  = 1;
    localparam int unsigned STAT_OVERFLOW = 2;
    localparam int unsigned STAT_IPL_LSB  = 13;

    typedef struct packed {
        logic [22:0] addr;  // address bits [23:1]
        logic        a0;
        logic        sz;
        logic        rw;
        logic [15:0] data;
    } pistormx_cmd_t;

endpackage

// File: rtl/pistormx_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module pistormx_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 42
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr];
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/pistormx_txn_queue.sv
// Pi-side front end for the 68K bus engine: synchronises Pi register writes,
// assembles them into bus commands, queues them and returns read data/status.
module pistormx_txn_queue
    import pistormx_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        M68K_CLK,
    input  logic        RESET,
    input  logic [1:0]  PI_A,
    input  logic        PI_RD,
    input  logic        PI_WR,
    input  logic [15:0] PI_D_IN,
    output logic [15:0] PI_D_OUT,
    output logic        PI_D_OE,
    output logic        PI_TXN_IN_PROGRESS,
    input  logic [2:0]  IPL,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic [22:0] CMD_ADDR,
    output logic        CMD_A0,
    output logic        CMD_SZ,
    output logic        CMD_RW,
    output logic [15:0] CMD_DATA,
    input  logic        RSP_VALID,
    input  logic [15:0] RSP_DATA,
    output logic        ST_RESET_OUT
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = 19;

    // WR, A and D share one chain so they stay aligned.
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic          wr_prev_q;
    logic          s_wr;
    logic [1:0]    s_a;
    logic [15:0]   s_d;
    logic          wr_event;

    logic [15:0]   data_stage_q, data_stage_d;
    logic [14:0]   addr_lo_q, addr_lo_d;
    logic          a0_q, a0_d;
    logic          pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          st_reset_q, st_reset_d;
    logic          busy_q, busy_d;

    pistormx_cmd_t new_cmd;
    pistormx_cmd_t head;
    logic          push_req, push_ok, pop;
    logic          full, empty;
    logic [CW-1:0] count, count_next;
    logic [15:0]   status_word;

    assign s_wr     = sync_q[SYNC_STAGES-1][18];
    assign s_a      = sync_q[SYNC_STAGES-1][17:16];
    assign s_d      = sync_q[SYNC_STAGES-1][15:0];
    assign wr_event = s_wr & ~wr_prev_q;

    assign new_cmd  = '{addr: {s_d[7:0], addr_lo_q}, a0: a0_q, sz: s_d[8], rw: s_d[9],
                        data: data_stage_q};
    assign pop      = ~empty & CMD_READY;
    assign push_req = wr_event & (s_a == REG_ADDR_HI);
    // A second outstanding read is refused just like a push into a full FIFO.
    assign push_ok  = push_req & ~(new_cmd.rw & pending_q) & (~full | pop);
    assign count_next = count + CW'(push_ok) - CW'(pop);

    always_ff @(posedge M68K_CLK) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            wr_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {PI_WR, PI_A, PI_D_IN};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            wr_prev_q <= s_wr;
        end
    end

    always_comb begin
        data_stage_d = data_stage_q;
        addr_lo_d    = addr_lo_q;
        a0_d         = a0_q;
        pending_d    = pending_q;
        overflow_d   = overflow_q;
        rd_data_d    = rd_data_q;
        st_reset_d   = st_reset_q;
        if (RSP_VALID) begin
            pending_d = 1'b0;
            rd_data_d = RSP_DATA;
        end
        if (wr_event) begin
            case (s_a)
                REG_DATA:    data_stage_d = s_d;
                REG_ADDR_LO: begin
                    addr_lo_d = s_d[15:1];
                    a0_d      = s_d[0];
                end
                REG_ADDR_HI: begin
                    if (!push_ok) overflow_d = 1'b1;
                    else if (new_cmd.rw) pending_d = 1'b1;
                end
                default: begin
                    st_reset_d = ~s_d[1];
                    if (s_d[2]) overflow_d = 1'b0;
                end
            endcase
        end
        busy_d = (count_next == CW'(DEPTH)) | pending_d | wr_event;
    end

    always_ff @(posedge M68K_CLK) begin
        if (RESET) begin
            data_stage_q <= '0;
            addr_lo_q    <= '0;
            a0_q         <= 1'b0;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
            rd_data_q    <= '0;
            st_reset_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_stage_q <= data_stage_d;
            addr_lo_q    <= addr_lo_d;
            a0_q         <= a0_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            rd_data_q    <= rd_data_d;
            st_reset_q   <= st_reset_d;
            busy_q       <= busy_d;
        end
    end

    pistormx_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pistormx_cmd_t))
    ) u_fifo (
        .clk   (M68K_CLK),
        .reset (RESET),
        .push  (push_ok),
        .pop   (pop),
        .wdata (new_cmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Pi read path is deliberately unsynchronised: the Pi holds A/RD stable.
    always_comb begin
        status_word                         = '0;
        status_word[STAT_IPL_LSB +: 3]      = IPL;
        status_word[STAT_OVERFLOW]          = overflow_q;
        status_word[STAT_PENDING]           = pending_q;
        status_word[STAT_FULL]              = full;
        PI_D_OE  = PI_RD & ((PI_A == REG_DATA) | (PI_A == REG_STATUS));
        PI_D_OUT = '0;
        if (PI_A == REG_DATA) PI_D_OUT = rd_data_q;
        else if (PI_A == REG_STATUS) PI_D_OUT = status_word;
    end

    assign PI_TXN_IN_PROGRESS = busy_q;
    assign ST_RESET_OUT       = st_reset_q;
    assign CMD_VALID          = ~empty;
    assign CMD_ADDR           = head.addr;
    assign CMD_A0             = head.a0;
    assign CMD_SZ             = head.sz;
    assign CMD_RW             = head.rw;
    assign CMD_DATA           = head.data;

endmodule

// File: tb/tb_pistormx_txn_queue.sv
// Bench for pistormx_txn_queue: directed and random Pi register traffic
// checked against a queue-based model of the register/command rules.
module tb_pistormx_txn_queue;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  PI_A = '0;
    logic        PI_RD = 1'b0, PI_WR = 1'b0;
    logic [15:0] PI_D_IN = '0, PI_D_OUT;
    logic        PI_D_OE, PI_TXN_IN_PROGRESS;
    logic [2:0]  IPL = '0;
    logic        CMD_VALID, CMD_READY = 1'b0;
    logic [22:0] CMD_ADDR;
    logic        CMD_A0, CMD_SZ, CMD_RW;
    logic [15:0] CMD_DATA;
    logic        RSP_VALID = 1'b0;
    logic [15:0] RSP_DATA = '0;
    logic        ST_RESET_OUT;

    always #5 clk = ~clk;

    pistormx_txn_queue #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .M68K_CLK(clk), .RESET(RESET), .PI_A(PI_A), .PI_RD(PI_RD), .PI_WR(PI_WR),
        .PI_D_IN(PI_D_IN), .PI_D_OUT(PI_D_OUT), .PI_D_OE(PI_D_OE),
        .PI_TXN_IN_PROGRESS(PI_TXN_IN_PROGRESS), .IPL(IPL), .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_A0(CMD_A0), .CMD_SZ(CMD_SZ),
        .CMD_RW(CMD_RW), .CMD_DATA(CMD_DATA), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
        .ST_RESET_OUT(ST_RESET_OUT)
    );

    typedef struct {
        logic [22:0] addr;
        logic        a0, sz, rw;
        logic [15:0] data;
    } cmd_m_t;

    cmd_m_t      q[$];
    logic [15:0] m_data_stage, m_rd;
    logic [14:0] m_addr_lo;
    logic        m_a0, m_pending, m_ovf, m_st_reset;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic model_reset();
        q.delete();
        m_data_stage = '0; m_rd = '0; m_addr_lo = '0;
        m_a0 = 1'b0; m_pending = 1'b0; m_ovf = 1'b0; m_st_reset = 1'b0;
    endtask

    function automatic logic m_full();
        return q.size() == DEPTH;
    endfunction

    task automatic model_write(input logic [1:0] a, input logic [15:0] d);
        cmd_m_t c;
        case (a)
            2'd0: m_data_stage = d;
            2'd1: begin m_addr_lo = d[15:1]; m_a0 = d[0]; end
            2'd2: begin
                c.addr = {d[7:0], m_addr_lo}; c.a0 = m_a0; c.sz = d[8]; c.rw = d[9];
                c.data = m_data_stage;
                if (m_full() || (c.rw && m_pending)) m_ovf = 1'b1;
                else begin
                    q.push_back(c);
                    if (c.rw) m_pending = 1'b1;
                end
            end
            default: begin
                m_st_reset = ~d[1];
                if (d[2]) m_ovf = 1'b0;
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        logic [15:0] st;
        st = {IPL, 10'd0, m_ovf, m_pending, m_full()};
        check({tag, ".cmd_valid"}, 64'(CMD_VALID), 64'(q.size() != 0));
        if (q.size() != 0)
            check({tag, ".cmd_head"}, 64'({CMD_ADDR, CMD_A0, CMD_SZ, CMD_RW, CMD_DATA}),
                  64'({q[0].addr, q[0].a0, q[0].sz, q[0].rw, q[0].data}));
        check({tag, ".busy"}, 64'(PI_TXN_IN_PROGRESS), 64'(m_full() | m_pending));
        check({tag, ".st_reset"}, 64'(ST_RESET_OUT), 64'(m_st_reset));
        PI_A = 2'd3; PI_RD = 1'b1; #1;
        check({tag, ".status_rd"}, 64'({PI_D_OE, PI_D_OUT}), 64'({1'b1, st}));
        PI_A = 2'd0; #1;
        check({tag, ".data_rd"}, 64'({PI_D_OE, PI_D_OUT}), 64'({1'b1, m_rd}));
        PI_A = 2'd1; #1;
        check({tag, ".addr_rd_oe"}, 64'(PI_D_OE), 64'(0));
        PI_RD = 1'b0;
    endtask

    task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
        PI_A = a; PI_D_IN = d; PI_WR = 1'b1;
        repeat (3) tick();
        PI_WR = 1'b0;
        repeat (4) tick();
        model_write(a, d);
    endtask

    task automatic pop_one();
        CMD_READY = 1'b1;
        tick();
        CMD_READY = 1'b0;
        void'(q.pop_front());
    endtask

    task automatic rsp(input logic [15:0] d);
        RSP_DATA = d; RSP_VALID = 1'b1;
        tick();
        RSP_VALID = 1'b0;
        m_pending = 1'b0; m_rd = d;
    endtask

    initial begin
        logic [15:0] d;
        model_reset();
        repeat (2) tick();
        RESET = 1'b0;
        tick();
        check_state("reset");

        // First command: latency from PI_WR rise and field packing.
        pi_write(2'd0, 16'hBEEF);
        pi_write(2'd1, 16'h1234);
        PI_A = 2'd2; PI_D_IN = 16'h0000; PI_WR = 1'b1;
        tick(); tick();
        check("lat.valid_c2", 64'(CMD_VALID), 64'(0));
        tick();
        check("lat.valid_c3", 64'(CMD_VALID), 64'(1));
        check("lat.busy_c3", 64'(PI_TXN_IN_PROGRESS), 64'(1));
        check("lat.addr", 64'(CMD_ADDR), 64'h00091A);
        PI_WR = 1'b0;
        repeat (4) tick();
        model_write(2'd2, 16'h0000);
        check_state("first_cmd");
        pop_one();
        check_state("first_pop");

        // Read command keeps the Pi waiting until the response arrives.
        pi_write(2'd2, 16'h0312);
        check_state("read_cmd");
        pop_one();
        repeat (5) tick();
        check_state("read_wait");
        rsp(16'hCAFE);
        check_state("read_done");

        // Random register traffic with occasional pops and responses.
        for (int i = 0; i < 40; i++) begin
            IPL = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    pi_write(2'd0, d);
                2, 3:    pi_write(2'd1, d);
                4, 5, 6: pi_write(2'd2, d);
                7:       if (q.size() != 0) pop_one();
                8:       rsp(d);
                default: pi_write(2'd3, d & 16'h0006);
            endcase
            check_state("rand");
        end

        // Overflow on a full FIFO, then clear it via STATUS.
        while (q.size() != 0) pop_one();
        rsp(16'h0001);
        pi_write(2'd3, 16'h0006);
        for (int i = 0; i < 5; i++) begin
            pi_write(2'd0, 16'(16'h1000 + i));
            pi_write(2'd2, 16'(i));
        end
        check_state("overflow");
        pi_write(2'd3, 16'h0006);
        check_state("ovf_clear");

        // Push into a full FIFO accepted when a pop lands on the same edge.
        PI_A = 2'd2; PI_D_IN = 16'h0055; PI_WR = 1'b1;
        tick(); tick();
        CMD_READY = 1'b1;
        tick();
        CMD_READY = 1'b0; PI_WR = 1'b0;
        repeat (4) tick();
        void'(q.pop_front());
        model_write(2'd2, 16'h0055);
        check_state("full_push_pop");
        while (q.size() != 0) begin
            check_state("drain");
            pop_one();
        end

        // Mid-operation reset flushes the queue and ignores a coincident response.
        pi_write(2'd2, 16'h0201);
        pi_write(2'd2, 16'h0002);
        pi_write(2'd2, 16'h0003);
        pi_write(2'd3, 16'h0000);
        check_state("pre_reset");
        RESET = 1'b1; RSP_DATA = 16'h5A5A; RSP_VALID = 1'b1;
        tick();
        RESET = 1'b0; RSP_VALID = 1'b0;
        model_reset();
        check_state("post_reset");

        // ST_RESET_OUT control and IPL in STATUS.
        IPL = 3'd5;
        pi_write(2'd3, 16'h0000);
        check_state("st_reset_on");
        pi_write(2'd3, 16'h0002);
        check_state("st_reset_off");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
